fetch_r: RTL and testbench
==========================

Name: fetch_r

Overview:
- Instruction-fetch stage of the 32-bit ARM-subset pipeline; sits directly upstream of the decode/register-read stage.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents inst_o, pc_o (ARM PC+8 view) and valid_o to decode.
- Honours the hazard stall, and the branch redirect and flush from execute.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
ADDR_W, 32, instruction address width (word aligned, bits [1:0] always 0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
imem_addr_o  out  ADDR_W  fetch address to instruction memory
imem_rd_en_o  out  1  read enable; data returned on imem_data_i next cycle
imem_data_i  in  32  read data for the address issued last cycle
stall_i  in  1  decode cannot accept this cycle; hold the current output
branch_i  in  1  execute resolved a taken branch this cycle
branch_target_i  in  ADDR_W  redirect address, valid when branch_i=1
valid_o  out  1  inst_o/pc_o carry a real instruction
inst_o  out  32  instruction word to decode
pc_o  out  ADDR_W  instruction address + 8 (ARM PC read value)
flush_o  out  1  kill the instruction currently held in decode
fetch_cnt_o  out  32  perf counter (see Optional Feature)
bubble_cnt_o  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset values:
  - State: pc_q=RESET_VECTOR, state=RESET, req_valid_q=0, hold_valid_q=0.
  - Outputs: valid_o=0, flush_o=0, imem_rd_en_o=0, counters=0.
  - Reset asserted mid-operation discards any in-flight read and the hold register.
- State machine:
  - RESET: one cycle, no issue; always goes to RUN.
  - RUN:
    - Issue: imem_addr_o=pc_q, imem_rd_en_o=1.
    - Update: pc_q<=pc_q+4, req_pc_q<=pc_q, req_valid_q<=1.
    - stall_i -> STALL; branch_i -> REDIRECT.
  - STALL:
    - imem_rd_en_o=0; pc_q is held.
    - On the entry cycle, if req_valid_q and !hold_valid_q, capture hold_inst_q<=imem_data_i and hold_valid_q<=1.
    - stall_i low -> RUN: the held word is presented first and a new read issues the same cycle.
  - REDIRECT:
    - Entered on branch_i. On the branch cycle: pc_q<=branch_target_i, req_valid_q<=0, hold_valid_q<=0.
    - Next cycle: issue at the target, valid_o=0 (one bubble), then RUN.
- Output mux and flush:
  - inst_o = hold_valid_q ? hold_inst_q : imem_data_i.
  - pc_o = (hold_valid_q ? hold_pc_q : req_pc_q) + 8, modulo 2^ADDR_W.
  - valid_o = (hold_valid_q | req_valid_q) & !branch_i.
  - flush_o = branch_i, combinational, same cycle.
- Priority: reset > branch_i > stall_i. A branch during a stall discards the hold register and leaves STALL for REDIRECT.
- Hold draining: when stall drops with hold_valid_q=1, the hold is consumed this cycle (hold_valid_q<=0). The read issued this cycle returns next cycle, so there is no gap and no duplicate.
- Address handling: PC wraps at 2^ADDR_W with no trap. branch_target_i[1:0] is forced to 0.
- Latency: first valid_o two cycles after reset deassertion; branch-to-first-target-valid is two cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt_o increments on each cycle with valid_o & !stall_i.
  - bubble_cnt_o increments on each cycle with !valid_o after RESET.
  - Both are 32-bit, saturating at 32'hFFFF_FFFF and cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are synthesised. Port list is identical in both builds.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum {RESET, RUN, STALL, REDIRECT};
  - localparams INST_W=32, PC_READ_OFFSET=8, INST_BYTES=4.
- One natural sub-module: fetch_hold_buf. It is the single-entry hold register (inst, pc, valid), with capture/consume/clear inputs.
- The counters stay inline under the macro.

Test Plan:
- Reset release, no stall, imem returns addr as data: valid_o rises on cycle 2; inst_o sequence 0x0,0x4,0x8; pc_o 0x8,0xC,0x10.
- stall_i high 3 cycles while inst 0x8 is presented: inst_o stays 0x8 and imem_rd_en_o stays 0 throughout. After release the sequence is 0x8 once, then 0xC, with no skip or duplicate.
- branch_i with target 0x100 while running: flush_o=1 and valid_o=0 that cycle, then one bubble. Next, inst_o = word at 0x100 with pc_o=0x108.
- branch_i and stall_i together, with the hold register full: branch wins, the hold is cleared and fetch resumes at the target with no stale word.
- reset asserted mid-stall with hold full: the next cycle has valid_o=0 and hold cleared, and the first fetch is RESET_VECTOR (also run with RESET_VECTOR=0x8000).
- With FETCH_PERF_CNT_EN, after scenario 1 plus a 3-cycle stall and 1 branch: fetch_cnt_o equals the accepted count and bubble_cnt_o equals the counted bubbles. Without the macro both read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cpu_pkg                                                                |
// | Shared types and constants for the ARM-subset pipeline front end.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package cpu_pkg;

    localparam int unsigned INST_W         = 32;
    localparam int unsigned PC_READ_OFFSET = 8;
    localparam int unsigned INST_BYTES     = 4;

    typedef enum logic [1:0] {
        RESET    = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_r_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_r_if                                                             |
// | Instruction-memory bus between the fetch stage and a 1-cycle imem.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface fetch_r_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rd_en_o;
    logic [INST_W-1:0] imem_data_i;

    modport master (
        output imem_addr_o,
        output imem_rd_en_o,
        input  imem_data_i
    );

    modport slave (
        input  imem_addr_o,
        input  imem_rd_en_o,
        output imem_data_i
    );

endinterface
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_hold_buf                                                         |
// | Single-entry skid register holding a fetched word across a stall.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module fetch_hold_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire                clk,
    input  wire                reset,
    input  wire                capture_i,
    input  wire                consume_i,
    input  wire                clear_i,
    input  wire [INST_W-1:0]   inst_i,
    input  wire [ADDR_W-1:0]   pc_i,
    output logic               valid_o,
    output logic [INST_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Clear (branch) outranks capture, which outranks consume.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_r.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_r                                                                |
// | Instruction-fetch stage: owns the PC, drives imem, feeds decode.       |
// | Optional perf counters under macro FETCH_PERF_CNT_EN.                  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module fetch_r
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  wire                clk,
    input  wire                reset,
    fetch_r_if.master          imem,
    input  wire                stall_i,
    input  wire                branch_i,
    input  wire [ADDR_W-1:0]   branch_target_i,
    output logic               valid_o,
    output logic [INST_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               flush_o,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        bubble_cnt_o
);

    localparam logic [ADDR_W-1:0] c_inst_step  = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] c_pc_offset  = ADDR_W'(PC_READ_OFFSET);
    localparam logic [ADDR_W-1:0] c_align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_valid_q, req_valid_d;

    logic              w_issue;
    logic              w_take_branch;
    logic              w_hold_capture;
    logic              w_hold_valid;
    logic [INST_W-1:0] w_hold_inst;
    logic [ADDR_W-1:0] w_hold_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:      state_d = RUN;
            RUN, STALL: begin
                if (branch_i)     state_d = REDIRECT;
                else if (stall_i) state_d = STALL;
                else              state_d = RUN;
            end
            REDIRECT:   state_d = branch_i ? REDIRECT : RUN;
            default:    state_d = RESET;
        endcase
    end

    // A redirect cycle always issues at the target: its output is a bubble, so stall is moot.
    always_comb begin
        w_issue       = 1'b0;
        w_take_branch = 1'b0;
        case (state_q)
            RUN, STALL: begin
                w_take_branch = branch_i;
                w_issue       = !branch_i && !stall_i;
            end
            REDIRECT: begin
                w_take_branch = branch_i;
                w_issue       = !branch_i;
            end
            default: begin
                w_issue       = 1'b0;
                w_take_branch = 1'b0;
            end
        endcase
    end

    assign imem.imem_addr_o  = pc_q;
    assign imem.imem_rd_en_o = w_issue;

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        if (w_take_branch) begin
            pc_d        = branch_target_i & c_align_mask;
            req_valid_d = 1'b0;
        end else if (w_issue) begin
            pc_d        = pc_q + c_inst_step;
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    // The word on imem_data_i is only there for this cycle; park it the first cycle decode refuses it.
    assign w_hold_capture = stall_i && req_valid_q && !w_hold_valid && !w_take_branch;

    fetch_hold_buf #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .capture_i (w_hold_capture),
        .consume_i (!stall_i),
        .clear_i   (w_take_branch),
        .inst_i    (imem.imem_data_i),
        .pc_i      (req_pc_q),
        .valid_o   (w_hold_valid),
        .inst_o    (w_hold_inst),
        .pc_o      (w_hold_pc)
    );

    assign inst_o  = w_hold_valid ? w_hold_inst : imem.imem_data_i;
    assign pc_o    = (w_hold_valid ? w_hold_pc : req_pc_q) + c_pc_offset;
    assign valid_o = (w_hold_valid || req_valid_q) && !branch_i;
    assign flush_o = branch_i;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_o && !stall_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (!valid_o && (state_q != RESET) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_r.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_r                                                             |
// | Directed vector bench for fetch_r; imem models return address as data.|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_fetch_r;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;

    logic        valid0, flush0, valid1, flush1;
    logic [31:0] inst0, pc0, fc0, bc0, inst1, pc1, fc1, bc1;

    always #5 clk = ~clk;

    fetch_r_if #(.ADDR_W(32)) bus0 ();
    fetch_r_if #(.ADDR_W(32)) bus1 ();

    fetch_r #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) u_dut0 (
        .clk             (clk),
        .reset           (reset),
        .imem            (bus0.master),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .valid_o         (valid0),
        .inst_o          (inst0),
        .pc_o            (pc0),
        .flush_o         (flush0),
        .fetch_cnt_o     (fc0),
        .bubble_cnt_o    (bc0)
    );

    fetch_r #(.ADDR_W(32), .RESET_VECTOR(32'h0000_8000)) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .imem            (bus1.master),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .valid_o         (valid1),
        .inst_o          (inst1),
        .pc_o            (pc1),
        .flush_o         (flush1),
        .fetch_cnt_o     (fc1),
        .bubble_cnt_o    (bc1)
    );

    always @(posedge clk) begin
        if (bus0.imem_rd_en_o) bus0.imem_data_i <= bus0.imem_addr_o;
        if (bus1.imem_rd_en_o) bus1.imem_data_i <= bus1.imem_addr_o;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        branch;
        logic [31:0] tgt;
        logic        e_valid;
        logic        e_flush;
        logic        e_rd;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic stall, input logic branch,
                                input logic [31:0] tgt, input logic ev, input logic ef,
                                input logic er, input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep);
        vec_t v;
        v.rst = rst; v.stall = stall; v.branch = branch; v.tgt = tgt;
        v.e_valid = ev; v.e_flush = ef; v.e_rd = er;
        v.e_addr = ea; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset           = v.rst;
        stall_i         = v.stall;
        branch_i        = v.branch;
        branch_target_i = v.tgt;
        @(negedge clk);
        chk({tag, ".valid"}, 32'(valid0), 32'(v.e_valid));
        chk({tag, ".flush"}, 32'(flush0), 32'(v.e_flush));
        chk({tag, ".rd_en"}, 32'(bus0.imem_rd_en_o), 32'(v.e_rd));
        if (v.e_rd) chk({tag, ".addr"}, bus0.imem_addr_o, v.e_addr);
        if (v.e_valid) begin
            chk({tag, ".inst"}, inst0, v.e_inst);
            chk({tag, ".pc"}, pc0, v.e_pc);
        end
    endtask

    vec_t        tbl [17];
    logic [31:0] exp_fc, exp_bc;

    initial begin
        //           rst stl br  tgt           ev ef rd  addr          inst          pc
        tbl[0]  = mk(0,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0,        32'h0);
        tbl[1]  = mk(0,  0,  0,  32'h0,        0, 0, 1,  32'h0,        32'h0,        32'h0);
        tbl[2]  = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h4,        32'h0,        32'h8);
        tbl[3]  = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h8,        32'h4,        32'hC);
        tbl[4]  = mk(0,  1,  0,  32'h0,        1, 0, 0,  32'h0,        32'h8,        32'h10);
        tbl[5]  = mk(0,  1,  0,  32'h0,        1, 0, 0,  32'h0,        32'h8,        32'h10);
        tbl[6]  = mk(0,  1,  0,  32'h0,        1, 0, 0,  32'h0,        32'h8,        32'h10);
        tbl[7]  = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'hC,        32'h8,        32'h10);
        tbl[8]  = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h10,       32'hC,        32'h14);
        tbl[9]  = mk(0,  0,  1,  32'h100,      0, 1, 0,  32'h0,        32'h0,        32'h0);
        tbl[10] = mk(0,  0,  0,  32'h0,        0, 0, 1,  32'h100,      32'h0,        32'h0);
        tbl[11] = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h104,      32'h100,      32'h108);
        tbl[12] = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h108,      32'h104,      32'h10C);
        tbl[13] = mk(0,  0,  1,  32'h203,      0, 1, 0,  32'h0,        32'h0,        32'h0);
        tbl[14] = mk(0,  0,  0,  32'h0,        0, 0, 1,  32'h200,      32'h0,        32'h0);
        tbl[15] = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h204,      32'h200,      32'h208);
        tbl[16] = mk(0,  0,  0,  32'h0,        1, 0, 1,  32'h208,      32'h204,      32'h20C);

`ifdef FETCH_PERF_CNT_EN
        exp_fc = 32'd7;
        exp_bc = 32'd5;
`else
        exp_fc = 32'd0;
        exp_bc = 32'd0;
`endif

        reset           = 1'b1;
        stall_i         = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 32'(valid0), 32'd0);
        chk("rst.flush", 32'(flush0), 32'd0);
        chk("rst.rd_en", 32'(bus0.imem_rd_en_o), 32'd0);
        chk("rst.fetch_cnt", fc0, 32'd0);
        chk("rst.bubble_cnt", bc0, 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i], $sformatf("row%0d", i));
        end
        chk("perf.fetch_cnt", fc0, exp_fc);
        chk("perf.bubble_cnt", bc0, exp_bc);

        // Branch while stalled with the hold register full: the parked word must not reappear.
        run_vec(mk(0, 1, 0, 32'h0,   1, 0, 0, 32'h0,   32'h208, 32'h210), "bs1");
        run_vec(mk(0, 1, 1, 32'h300, 0, 1, 0, 32'h0,   32'h0,   32'h0),   "bs2");
        run_vec(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h300, 32'h0,   32'h0),   "bs3");
        run_vec(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h304, 32'h300, 32'h308), "bs4");

        // Reset mid-stall with the hold register full.
        run_vec(mk(0, 1, 0, 32'h0,   1, 0, 0, 32'h0,   32'h304, 32'h30C), "rs1");
        run_vec(mk(1, 1, 0, 32'h0,   1, 0, 0, 32'h0,   32'h304, 32'h30C), "rs2");
        run_vec(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h0),   "rs3");
        chk("rs3.fetch_cnt", fc0, 32'd0);
        chk("rs3.bubble_cnt", bc0, 32'd0);
        chk("rs3.dut1.valid", 32'(valid1), 32'd0);
        chk("rs3.dut1.flush", 32'(flush1), 32'd0);
        chk("rs3.dut1.rd_en", 32'(bus1.imem_rd_en_o), 32'd0);
        chk("rs3.dut1.fetch_cnt", fc1, 32'd0);
        chk("rs3.dut1.bubble_cnt", bc1, 32'd0);
        run_vec(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h0,   32'h0,   32'h0),   "rs4");
        chk("rs4.dut1.rd_en", 32'(bus1.imem_rd_en_o), 32'd1);
        chk("rs4.dut1.addr", bus1.imem_addr_o, 32'h0000_8000);
        run_vec(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h4,   32'h0,   32'h8),   "rs5");
        chk("rs5.dut1.valid", 32'(valid1), 32'd1);
        chk("rs5.dut1.inst", inst1, 32'h0000_8000);
        chk("rs5.dut1.pc", pc1, 32'h0000_8008);

        // PC wraps past the top of the address space.
        run_vec(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,          32'h0,          32'h0), "wr1");
        run_vec(mk(0, 0, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFC,  32'h0,          32'h0), "wr2");
        run_vec(mk(0, 0, 0, 32'h0,         1, 0, 1, 32'h0,          32'hFFFF_FFFC,  32'h4), "wr3");
        run_vec(mk(0, 0, 0, 32'h0,         1, 0, 1, 32'h4,          32'h0,          32'h8), "wr4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
